morse_emit_char: RTL and testbench

Transmit-side counterpart of the Morse character capture block. It takes one Morse character as a length and a dit/dah bit pattern, in the same format the capture block produces, and keys it onto a single-bit `signal` line. Mark, inter-element, inter-character and inter-word timing come from the shared `dit_time`/`dah_time`/`word_time` values. It sits between the character-to-Morse lookup and the output pin/LED driver, and advances only on `ce` ticks, so all durations are counted in `ce` ticks.

---
 rtl/morse_emit_char_pkg.sv | 13 +
 rtl/morse_emit_char_if.sv | 27 ++
 rtl/morse_emit_char_counter.sv | 19 +
 rtl/morse_emit_char.sv | 84 ++++++++
 tb/tb_morse_emit_char.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/morse_emit_char_pkg.sv
// morse_emit_char_pkg: shared widths and FSM state encoding for the Morse emitter
package morse_emit_char_pkg;
    localparam int DEF_PULSE_CNT_W   = 16;
    localparam int DEF_MORSE_LEN_W   = 4;
    localparam int DEF_MAX_MORSE_LEN = 8;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_GAP,
        ST_DONE
    } state_e;
endpackage

// File: rtl/morse_emit_char_if.sv
// morse_emit_char_if: character request, timing inputs and keyed outputs of the emitter
interface morse_emit_char_if import morse_emit_char_pkg::*; #(
    parameter int PULSE_CNT_W   = DEF_PULSE_CNT_W,
    parameter int MORSE_LEN_W   = DEF_MORSE_LEN_W,
    parameter int MAX_MORSE_LEN = DEF_MAX_MORSE_LEN
);
    logic                     ce;
    logic                     start;
    logic [MORSE_LEN_W-1:0]   len;
    logic [MAX_MORSE_LEN-1:0] dits_dahs;
    logic                     word_end;
    logic [PULSE_CNT_W-1:0]   dit_time;
    logic [PULSE_CNT_W-1:0]   dah_time;
    logic [PULSE_CNT_W-1:0]   word_time;
    logic                     signal;
    logic                     busy;
    logic                     error;
    logic                     ceo;
    modport master (
        output ce, start, len, dits_dahs, word_end, dit_time, dah_time, word_time,
        input  signal, busy, error, ceo
    );
    modport slave (
        input  ce, start, len, dits_dahs, word_end, dit_time, dah_time, word_time,
        output signal, busy, error, ceo
    );
endinterface

// File: rtl/morse_emit_char_counter.sv
// morse_emit_char_counter: phase counter with synchronous load to SCLR_VAL and increment enable
module morse_emit_char_counter #(
    parameter int         W        = 16,
    parameter logic [W-1:0] SCLR_VAL = W'(1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sclr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign cnt_d = sclr_i ? SCLR_VAL : cnt_q + W'(1);
    // load wins over increment so a new phase always starts at SCLR_VAL
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else if (sclr_i | inc_i) cnt_q <= cnt_d;
    assign cnt_o = cnt_q;
endmodule

// File: rtl/morse_emit_char.sv
// morse_emit_char: keys one Morse character onto a single-bit line with dit/dah/word timing
module morse_emit_char import morse_emit_char_pkg::*; #(
    parameter int PULSE_CNT_W   = DEF_PULSE_CNT_W,
    parameter int MORSE_LEN_W   = DEF_MORSE_LEN_W,
    parameter int MAX_MORSE_LEN = DEF_MAX_MORSE_LEN
) (
    input logic               clk,
    input logic               rst,
    morse_emit_char_if.slave  m_if
);
    localparam logic [MORSE_LEN_W-1:0] MAX_LEN = MORSE_LEN_W'(MAX_MORSE_LEN);
    state_e                   state_q;
    logic                     sig_q, busy_q, err_q, we_q;
    logic [MAX_MORSE_LEN-1:0] dd_q;
    logic [MORSE_LEN_W-1:0]   idx_q;
    logic [PULSE_CNT_W-1:0]   dit_q, dah_q, word_q, cnt, raw_tgt, tgt;
    logic                     accept, in_phase, phase_end, mark_dah;
    // DONE also accepts so back-to-back characters carry no extra dead tick
    assign accept    = m_if.ce & m_if.start & (state_q == ST_IDLE || state_q == ST_DONE);
    assign in_phase  = state_q inside {ST_MARK, ST_SPACE, ST_GAP};
    assign mark_dah  = |(dd_q & (MAX_MORSE_LEN'(1) << idx_q));
    assign raw_tgt   = state_q == ST_MARK  ? (mark_dah ? dah_q : dit_q) :
                       state_q == ST_SPACE ? dit_q :
                       we_q ? word_q : dah_q;
    assign tgt       = raw_tgt == '0 ? PULSE_CNT_W'(1) : raw_tgt;
    assign phase_end = in_phase & (cnt >= tgt);
    morse_emit_char_counter #(.W(PULSE_CNT_W), .SCLR_VAL(PULSE_CNT_W'(1))) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .sclr_i (accept | (m_if.ce & phase_end)),
        .inc_i  (m_if.ce & in_phase & ~phase_end),
        .cnt_o  (cnt)
    );
    // character sequencer: latch request on accept, then walk marks/spaces and the trailing gap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            dd_q    <= '0;
            idx_q   <= '0;
            dit_q   <= '0;
            dah_q   <= '0;
            word_q  <= '0;
        end else if (m_if.ce) begin
            if (accept) begin
                dd_q   <= m_if.dits_dahs;
                we_q   <= m_if.word_end;
                dit_q  <= m_if.dit_time;
                dah_q  <= m_if.dah_time;
                word_q <= m_if.word_time;
                idx_q  <= m_if.len - MORSE_LEN_W'(1);
                busy_q <= 1'b1;
                err_q  <= m_if.len > MAX_LEN;
                sig_q  <= m_if.len != '0 && m_if.len <= MAX_LEN;
                state_q <= m_if.len > MAX_LEN ? ST_DONE : m_if.len == '0 ? ST_GAP : ST_MARK;
            end else begin
                case (state_q)
                    ST_MARK: if (phase_end) begin
                        sig_q   <= 1'b0;
                        state_q <= idx_q == '0 ? ST_GAP : ST_SPACE;
                        if (idx_q != '0) idx_q <= idx_q - MORSE_LEN_W'(1);
                    end
                    ST_SPACE: if (phase_end) begin
                        sig_q   <= 1'b1;
                        state_q <= ST_MARK;
                    end
                    ST_GAP: if (phase_end) state_q <= ST_DONE;
                    ST_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end
    assign m_if.signal = sig_q;
    assign m_if.busy   = busy_q;
    assign m_if.error  = err_q;
    assign m_if.ceo    = m_if.ce & (state_q == ST_DONE);
endmodule

// File: tb/tb_morse_emit_char.sv
// tb_morse_emit_char: directed checks of Morse character keying, gaps, errors, reset and ce gating
module tb_morse_emit_char;
    import morse_emit_char_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    morse_emit_char_if b ();
    morse_emit_char dut (.clk(clk), .rst(rst), .m_if(b));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] l, input logic [7:0] dd, input logic we,
                        output int k, output logic [63:0] pat, output logic busy_ok);
        b.len = l;
        b.dits_dahs = dd;
        b.word_end = we;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        k = 0;
        pat = '0;
        busy_ok = 1'b1;
        while (!b.ceo && k < 200) begin
            pat = {pat[62:0], b.signal};
            busy_ok &= b.busy;
            k++;
            tick();
        end
        busy_ok &= b.busy;
    endtask

    initial begin
        int k, ceo_k, hi, first_run, ceo_n, ceo_c, ceo_bad;
        logic [63:0] pat;
        logic busy_ok, in_first;
        b.ce = 1'b1;
        b.start = 1'b0;
        b.len = '0;
        b.dits_dahs = '0;
        b.word_end = 1'b0;
        b.dit_time = 16'd2;
        b.dah_time = 16'd6;
        b.word_time = 16'd14;
        tick();
        tick();
        chk("rst_signal", b.signal, 0);
        chk("rst_busy", b.busy, 0);
        chk("rst_error", b.error, 0);
        chk("rst_ceo", b.ceo, 0);
        rst = 1'b0;
        tick();

        send(4'd2, 8'b01, 1'b0, k, pat, busy_ok);
        chk("A_clks", k + 1, 17);
        chk("A_pattern", pat, 64'hCFC0);
        chk("A_busy_high", busy_ok, 1);
        tick();
        chk("A_busy_fall", b.busy, 0);
        chk("A_ceo_one_clk", b.ceo, 0);

        send(4'd1, 8'b0, 1'b1, k, pat, busy_ok);
        chk("E_clks", k + 1, 17);
        chk("E_pattern", pat, 64'hC000);
        tick();

        b.dit_time = 16'd0;
        send(4'd1, 8'b0, 1'b0, k, pat, busy_ok);
        chk("dit0_clks", k + 1, 8);
        chk("dit0_pattern", pat, 64'h40);
        b.dit_time = 16'd2;
        tick();

        send(4'd9, 8'hFF, 1'b0, k, pat, busy_ok);
        chk("err_clks", k + 1, 1);
        chk("err_flag", b.error, 1);
        chk("err_no_mark", b.signal, 0);
        chk("err_busy_until_done", b.busy, 1);
        tick();
        chk("err_sticky", b.error, 1);
        chk("err_busy_fall", b.busy, 0);

        send(4'd0, 8'h00, 1'b1, k, pat, busy_ok);
        chk("len0_clks", k + 1, 15);
        chk("len0_silent", pat, 0);
        chk("len0_err_cleared", b.error, 0);
        tick();

        b.len = 4'd3;
        b.dits_dahs = 8'h00;
        b.word_end = 1'b0;
        b.start = 1'b1;
        tick();
        pat = '0;
        ceo_k = -1;
        for (int i = 0; i < 23; i++) begin
            pat = {pat[62:0], b.signal};
            if (b.ceo && ceo_k < 0) ceo_k = i;
            if (i == 3) b.dits_dahs = 8'hFF;
            tick();
        end
        chk("S_repeat_pattern", pat, 64'h66603F);
        chk("S_ceo_at", ceo_k, 16);
        b.start = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        b.len = 4'd1;
        b.dits_dahs = 8'h01;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        tick();
        tick();
        chk("dah_before_rst", b.signal, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_signal", b.signal, 0);
        chk("rst_mid_busy", b.busy, 0);
        chk("rst_mid_ceo", b.ceo, 0);
        tick();
        rst = 1'b0;
        tick();
        send(4'd1, 8'b0, 1'b1, k, pat, busy_ok);
        chk("after_rst_E_pattern", pat, 64'hC000);
        chk("after_rst_E_clks", k + 1, 17);
        tick();

        b.len = 4'd2;
        b.dits_dahs = 8'b01;
        b.word_end = 1'b0;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        hi = 0;
        first_run = 0;
        in_first = 1'b1;
        ceo_n = 0;
        ceo_c = -1;
        ceo_bad = 0;
        for (int c = 1; c <= 60; c++) begin
            b.ce = (c % 3 == 0);
            #1;
            if (b.signal) hi++;
            if (in_first && b.signal) first_run++;
            else in_first = 1'b0;
            if (b.ceo) begin
                ceo_n++;
                ceo_c = c;
                if (!b.ce) ceo_bad++;
            end
            @(posedge clk);
            #1;
        end
        b.ce = 1'b1;
        chk("ce3_first_mark_clks", first_run, 6);
        chk("ce3_mark_clks", hi, 24);
        chk("ce3_ceo_width", ceo_n, 1);
        chk("ce3_ceo_at", ceo_c, 51);
        chk("ce3_ceo_with_ce", ceo_bad, 0);
        chk("ce3_idle_after", b.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
